// File: rtl/add_sub_serial_ctrl.sv
// Bit-serial add/subtract sequencer streaming operands LSB-first through one full_add_sub_1bit cell.
// Optional two's-complement overflow output enabled by defining ADD_SUB_SERIAL_OVF_EN.

module full_add_sub_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic m,
    output logic sum,
    output logic cout
);
    logic a_eff;

    // Subtract borrow is the majority of (~a, b, bin), so inverting a unifies both modes
    assign a_eff = a ^ m;
    assign sum   = a ^ b ^ cin;
    assign cout  = (a_eff & b) | (a_eff & cin) | (b & cin);
endmodule

module add_sub_serial_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             m,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef ADD_SUB_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic             mode;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             cell_sum;
    logic             cell_cout;
    logic             last_bit;

    full_add_sub_1bit u_cell (
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .cin  (carry),
        .m    (mode),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sh_a   <= '0;
            sh_b   <= '0;
            mode   <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        mode  <= m;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    result <= {cell_sum, result[WIDTH-1:1]};
                    sh_a   <= sh_a >> 1;
                    sh_b   <= sh_b >> 1;
                    carry  <= cell_cout;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        cout  <= cell_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ADD_SUB_SERIAL_OVF_EN
    logic a_msb;
    logic b_msb;
    logic ovf_next;

    // The last cell sum is the result MSB, so overflow resolves on the same edge as cout
    assign ovf_next = (mode ? (a_msb != b_msb) : (a_msb == b_msb)) && (cell_sum != a_msb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == IDLE && start) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (state == RUN && last_bit) begin
            ovf <= ovf_next;
        end
    end
`endif

endmodule

// File: tb/tb_add_sub_serial_ctrl.sv
// Scoreboard bench for add_sub_serial_ctrl (WIDTH=8) with directed, hand-computed vectors.
// Checks ovf as well when ADD_SUB_SERIAL_OVF_EN is defined.

module tb_add_sub_serial_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         m = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
`ifdef ADD_SUB_SERIAL_OVF_EN
    logic         ovf;
`endif

    add_sub_serial_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .m      (m),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
`ifdef ADD_SUB_SERIAL_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;
    int n_done = 0;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         o;
        int           acc;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: pop one expectation per done pulse
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            n_done++;
            chk("busy_low_with_done", {31'd0, busy}, 32'd0);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending operation", cyc);
            end else begin
                e = sb.pop_front();
                chk("result", {24'd0, result}, {24'd0, e.r});
                chk("cout", {31'd0, cout}, {31'd0, e.c});
`ifdef ADD_SUB_SERIAL_OVF_EN
                chk("ovf", {31'd0, ovf}, {31'd0, e.o});
`endif
                chk("done_latency", cyc - e.acc, W);
            end
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while ((busy || done) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: got busy=%0b done=%0b expected idle within 100 cycles", busy, done);
        end
    endtask

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic im, input logic ic,
                         input logic [W-1:0] er, input logic ec, input logic eo);
        exp_t e;
        wait_idle();
        a = ia; b = ib; m = im; cin = ic; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        e.r = er; e.c = ec; e.o = eo; e.acc = cyc;
        sb.push_back(e);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || done) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    logic [W-1:0] b2b_a [3] = '{8'h5A, 8'h10, 8'hFF};
    logic [W-1:0] b2b_b [3] = '{8'h3C, 8'h01, 8'h01};
    logic         b2b_m [3] = '{1'b0, 1'b1, 1'b0};
    logic [W-1:0] b2b_r [3] = '{8'h96, 8'h0F, 8'h00};
    logic         b2b_c [3] = '{1'b0, 1'b0, 1'b1};
    logic         b2b_o [3] = '{1'b1, 1'b0, 1'b0};

    initial begin
        int   d0;
        int   first;
        int   t;
        logic got;
        logic prevb;
        exp_t e;

        first = 0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", {24'd0, result}, 32'd0);
        chk("reset_cout", {31'd0, cout}, 32'd0);
`ifdef ADD_SUB_SERIAL_OVF_EN
        chk("reset_ovf", {31'd0, ovf}, 32'd0);
`endif
        rst_n = 1'b1;

        issue(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
        issue(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        issue(8'h7F, 8'h00, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);
        issue(8'h10, 8'h01, 1'b1, 1'b0, 8'h0F, 1'b0, 1'b0);
        issue(8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
        drain();

        // Lockout: second start at E3 must be ignored
        d0 = n_done;
        issue(8'h22, 8'h11, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        a = 8'hAA; b = 8'h55; m = 1'b1; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        repeat (12) @(negedge clk);
        chk("lockout_done_count", n_done - d0, 1);

        // Reset in the middle of RUN discards the operation
        issue(8'h0F, 8'h0F, 1'b0, 1'b0, 8'h1E, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_result", {24'd0, result}, 32'd0);
        chk("midrst_cout", {31'd0, cout}, 32'd0);
`ifdef ADD_SUB_SERIAL_OVF_EN
        chk("midrst_ovf", {31'd0, ovf}, 32'd0);
`endif
        sb.delete();
        d0 = n_done;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("no_done_after_reset", n_done - d0, 0);
        issue(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);
        drain();

        // Back-to-back with start held high: accepts every WIDTH+2 cycles
        wait_idle();
        a = b2b_a[0]; b = b2b_b[0]; m = b2b_m[0]; cin = 1'b0; start = 1'b1;
        prevb = 1'b0;
        for (int k = 0; k < 3; k++) begin
            got = 1'b0;
            t = 0;
            while (!got && t < 30) begin
                @(posedge clk);
                #1;
                if (busy && !prevb) got = 1'b1;
                prevb = busy;
                t++;
            end
            if (!got) begin
                n_checks++;
                n_fail++;
                $display("FAIL b2b_accept_timeout: got no accept for op %0d expected one within 30 cycles", k);
            end else begin
                if (k == 0) first = cyc;
                chk("b2b_accept_cycle", cyc - first, 10 * k);
                e.r = b2b_r[k]; e.c = b2b_c[k]; e.o = b2b_o[k]; e.acc = cyc;
                sb.push_back(e);
                if (k < 2) begin
                    a = b2b_a[k+1]; b = b2b_b[k+1]; m = b2b_m[k+1];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        drain();
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
